// File: rtl/cdb_loader_if.sv
// -----------------------------------------------------------------------------
// cdb_loader_if
// Bundles the literal-stream handshake, the clause-database write port and the
// status outputs of cdb_loader.
//   load_start, lit_valid, lit_var, lit_neg : literal source -> loader
//   lit_ready                               : loader -> literal source
//   cdb_we, cdb_addr, cdb_wdata             : loader -> clause database
//   clause_cnt, sat_start, load_busy,
//   load_err                                : loader status
//   taut_drop                               : present only with CDB_TAUTOLOGY_DROP_EN
// Modports: master = literal source / observer side, slave = the loader.
// -----------------------------------------------------------------------------
interface cdb_loader_if #(
  parameter int VAR_NUM        = 7,
  parameter int VAR_NUM_LOG    = 3,
  parameter int CLAUSE_NUM_LOG = 3
);
  logic                      load_start;
  logic                      lit_valid;
  logic                      lit_ready;
  logic [VAR_NUM_LOG-1:0]    lit_var;
  logic                      lit_neg;
  logic                      cdb_we;
  logic [CLAUSE_NUM_LOG-1:0] cdb_addr;
  logic [2*VAR_NUM-1:0]      cdb_wdata;
  logic [CLAUSE_NUM_LOG:0]   clause_cnt;
  logic                      sat_start;
  logic                      load_busy;
  logic                      load_err;
`ifdef CDB_TAUTOLOGY_DROP_EN
  logic                      taut_drop;
`endif

  modport master (
`ifdef CDB_TAUTOLOGY_DROP_EN
    input  taut_drop,
`endif
    output load_start, lit_valid, lit_var, lit_neg,
    input  lit_ready, cdb_we, cdb_addr, cdb_wdata, clause_cnt,
           sat_start, load_busy, load_err
  );

  modport slave (
`ifdef CDB_TAUTOLOGY_DROP_EN
    output taut_drop,
`endif
    input  load_start, lit_valid, lit_var, lit_neg,
    output lit_ready, cdb_we, cdb_addr, cdb_wdata, clause_cnt,
           sat_start, load_busy, load_err
  );
endinterface

// File: rtl/cdb_loader.sv
// -----------------------------------------------------------------------------
// cdb_loader
// Front end of sat_top: assembles a DIMACS-style literal stream into clause
// words (2 bits per variable: 01 pos, 10 neg, 11 both), writes one word per
// clause into the clause database and pulses sat_start when the load ends.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, aborts any session
//   bus  - cdb_loader_if.slave (literal handshake, cdb write port, status)
// Optional feature macro: CDB_TAUTOLOGY_DROP_EN - tautological clauses (any
// field = 11) are dropped instead of written, flagged on bus.taut_drop.
// -----------------------------------------------------------------------------
module cdb_loader #(
  parameter int VAR_NUM        = 7,
  parameter int VAR_NUM_LOG    = 3,
  parameter int CLAUSE_NUM     = 7,
  parameter int CLAUSE_NUM_LOG = 3,
  parameter int MAX_LITS       = 3
) (
  input logic          clk,
  input logic          rst,
  cdb_loader_if.slave  bus
);
  localparam int W     = 2 * VAR_NUM;
  localparam int LC_W  = $clog2(MAX_LITS + 1);
  localparam int CNT_W = CLAUSE_NUM_LOG + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [LC_W-1:0]    lit_cnt_q, lit_cnt_d;
  logic [CNT_W-1:0]   clause_cnt_q, clause_cnt_d;
  logic               err_q, err_d;

  logic [W-1:0]       lit_mask;
  logic               lit_xfer;
  logic               lit_zero;
  logic               var_oob;
  logic               lits_full;
  logic               cdb_full;
  logic               taut_w;

  // One-hot field mask for the incoming literal; lit_var = 0 selects no field.
  generate
    for (genvar gi = 0; gi < VAR_NUM; gi++) begin : gen_lit_mask
      assign lit_mask[2*gi +: 2] = (bus.lit_var == VAR_NUM_LOG'(gi + 1)) ?
                                   (bus.lit_neg ? 2'b10 : 2'b01) : 2'b00;
    end
  endgenerate

`ifdef CDB_TAUTOLOGY_DROP_EN
  logic [VAR_NUM-1:0] field_both;
  generate
    for (genvar gi = 0; gi < VAR_NUM; gi++) begin : gen_taut
      assign field_both[gi] = &acc_q[2*gi +: 2];
    end
  endgenerate
  assign taut_w        = |field_both;
  assign bus.taut_drop = (state_q == S_WRITE) && taut_w;
`else
  assign taut_w = 1'b0;
`endif

  // lit_ready depends on state only, so a transfer is valid && LOAD.
  assign lit_xfer  = (state_q == S_LOAD) && bus.lit_valid;
  assign lit_zero  = (bus.lit_var == '0);
  // Extra MSB keeps the range check meaningful when VAR_NUM fills the id width.
  assign var_oob   = {1'b0, bus.lit_var} > (VAR_NUM_LOG + 1)'(VAR_NUM);
  assign lits_full = (lit_cnt_q == LC_W'(MAX_LITS));
  assign cdb_full  = (clause_cnt_q == CNT_W'(CLAUSE_NUM));

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    lit_cnt_d    = lit_cnt_q;
    clause_cnt_d = clause_cnt_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.load_start) begin
          state_d      = S_LOAD;
          acc_d        = '0;
          lit_cnt_d    = '0;
          clause_cnt_d = '0;
          err_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (lit_xfer) begin
          if (var_oob || (!lit_zero && lits_full) ||
              (lit_zero && (lit_cnt_q != '0) && cdb_full)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (!lit_zero) begin
            acc_d     = acc_q | lit_mask;
            lit_cnt_d = lit_cnt_q + LC_W'(1);
          end else if (lit_cnt_q != '0) begin
            state_d = S_WRITE;
          end else begin
            // Empty clause marks the end of the formula.
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        acc_d     = '0;
        lit_cnt_d = '0;
        if (!taut_w) begin
          clause_cnt_d = clause_cnt_q + CNT_W'(1);
        end
        state_d = (clause_cnt_d == CNT_W'(CLAUSE_NUM)) ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      lit_cnt_q    <= '0;
      clause_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      lit_cnt_q    <= lit_cnt_d;
      clause_cnt_q <= clause_cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.lit_ready  = (state_q == S_LOAD);
  assign bus.cdb_we     = (state_q == S_WRITE) && !taut_w;
  assign bus.cdb_addr   = clause_cnt_q[CLAUSE_NUM_LOG-1:0];
  assign bus.cdb_wdata  = (state_q == S_WRITE) ? acc_q : '0;
  assign bus.clause_cnt = clause_cnt_q;
  assign bus.sat_start  = (state_q == S_DONE);
  assign bus.load_busy  = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.load_err   = err_q;
endmodule

// File: tb/tb_cdb_loader.sv
module tb_cdb_loader;
  localparam int VN = 7;
  localparam int VL = 3;
  localparam int CN = 7;
  localparam int CL = 3;
  localparam int ML = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_loader_if #(.VAR_NUM(VN), .VAR_NUM_LOG(VL), .CLAUSE_NUM_LOG(CL)) bus ();
  cdb_loader_if #(.VAR_NUM(6),  .VAR_NUM_LOG(VL), .CLAUSE_NUM_LOG(CL)) bus6 ();

  cdb_loader #(.VAR_NUM(VN), .VAR_NUM_LOG(VL), .CLAUSE_NUM(CN),
               .CLAUSE_NUM_LOG(CL), .MAX_LITS(ML))
    u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Narrower variable range so that lit_var = 7 is out of range.
  cdb_loader #(.VAR_NUM(6), .VAR_NUM_LOG(VL), .CLAUSE_NUM(CN),
               .CLAUSE_NUM_LOG(CL), .MAX_LITS(ML))
    u_dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

  int total = 0;
  int bad   = 0;

  // Captured DUT activity
  int got_addr[$];
  int got_data[$];
  int sat_cnt = 0;
  int w_cnt6  = 0;
`ifdef CDB_TAUTOLOGY_DROP_EN
  int taut_cnt = 0;
`endif

  // Session description and reference expectations
  int cl_var [CN][ML];
  bit cl_neg [CN][ML];
  int cl_len [CN];
  int n_cl;
  int exp_addr[$];
  int exp_data[$];
  int exp_cnt;
  int exp_taut;

  typedef struct packed {
    logic [2:0][3:0] v;
    logic [2:0]      n;
    logic [1:0]      len;
    logic [13:0]     word;
    logic            taut;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cdb_we === 1'b1) begin
        got_addr.push_back(int'(bus.cdb_addr));
        got_data.push_back(int'(bus.cdb_wdata));
        check("ready_low_in_write", int'(bus.lit_ready), 0);
      end
      if (bus.sat_start === 1'b1) sat_cnt++;
      if (bus6.cdb_we === 1'b1) w_cnt6++;
`ifdef CDB_TAUTOLOGY_DROP_EN
      if (bus.taut_drop === 1'b1) taut_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    got_addr.delete();
    got_data.delete();
    sat_cnt = 0;
`ifdef CDB_TAUTOLOGY_DROP_EN
    taut_cnt = 0;
`endif
  endtask

  // Reference: each clause word is the OR of (neg ? 2 : 1) << 2*(var-1).
  function automatic void model();
    exp_addr.delete();
    exp_data.delete();
    exp_cnt  = 0;
    exp_taut = 0;
    for (int c = 0; c < n_cl; c++) begin
      int w;
      if (exp_cnt == CN) break;
      w = 0;
      for (int k = 0; k < cl_len[c]; k++)
        w |= (cl_neg[c][k] ? 2 : 1) << (2 * (cl_var[c][k] - 1));
`ifdef CDB_TAUTOLOGY_DROP_EN
      begin
        bit t;
        t = 1'b0;
        for (int v = 0; v < VN; v++)
          if (((w >> (2 * v)) & 3) == 3) t = 1'b1;
        if (t) begin
          exp_taut++;
          continue;
        end
      end
`endif
      exp_addr.push_back(exp_cnt);
      exp_data.push_back(w);
      exp_cnt++;
    end
  endfunction

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_lit(input int v, input bit neg, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.lit_valid = 1'b1;
    bus.lit_var   = VL'(v);
    bus.lit_neg   = neg;
    n = 0;
    while (bus.lit_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("ready_timeout", n, 0);
    tick();
    bus.lit_valid = 1'b0;
    bus.lit_var   = '0;
    bus.lit_neg   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.load_busy === 1'b1 || bus.sat_start === 1'b1) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("idle_timeout", n, 0);
  endtask

  task automatic drive_session(input bit gaps);
    clear_capture();
    model();
    start_load();
    for (int c = 0; c < n_cl; c++) begin
      for (int k = 0; k < cl_len[c]; k++) send_lit(cl_var[c][k], cl_neg[c][k], gaps);
      send_lit(0, 1'b0, gaps);
    end
    if (exp_cnt < CN) send_lit(0, 1'b0, gaps);
    wait_idle();
  endtask

  task automatic check_session(input string nm);
    check({nm, "_nwrites"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", nm, i), got_data[i], exp_data[i]);
    end
    check({nm, "_clause_cnt"}, int'(bus.clause_cnt), exp_cnt);
    check({nm, "_sat_pulses"}, sat_cnt, 1);
    check({nm, "_load_err"}, int'(bus.load_err), 0);
`ifdef CDB_TAUTOLOGY_DROP_EN
    check({nm, "_taut_drops"}, taut_cnt, exp_taut);
`endif
  endtask

  task automatic set_vec(input int i, input int v0, input bit n0, input int v1,
                         input bit n1, input int v2, input bit n2, input int len,
                         input int word, input bit taut);
    tbl[i].v[0] = 4'(v0); tbl[i].n[0] = n0;
    tbl[i].v[1] = 4'(v1); tbl[i].n[1] = n1;
    tbl[i].v[2] = 4'(v2); tbl[i].n[2] = n2;
    tbl[i].len  = 2'(len);
    tbl[i].word = 14'(word);
    tbl[i].taut = taut;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w;
    bus.load_start  = 1'b0; bus.lit_valid  = 1'b0; bus.lit_var  = '0; bus.lit_neg  = 1'b0;
    bus6.load_start = 1'b0; bus6.lit_valid = 1'b0; bus6.lit_var = '0; bus6.lit_neg = 1'b0;

    // Single-clause vectors: literals, expected clause word, tautology flag
    set_vec(0, 1, 0, 2, 1, 3, 0, 3, 14'h0019, 0);
    set_vec(1, 7, 1, 0, 0, 0, 0, 1, 14'h2000, 0);
    set_vec(2, 4, 0, 4, 0, 0, 0, 2, 14'h0040, 0);
    set_vec(3, 2, 0, 2, 1, 0, 0, 2, 14'h000C, 1);
    set_vec(4, 5, 1, 6, 0, 7, 0, 3, 14'h1600, 0);
    set_vec(5, 3, 1, 0, 0, 0, 0, 1, 14'h0020, 0);

    // Reset state
    repeat (3) tick();
    check("rst_lit_ready",  int'(bus.lit_ready), 0);
    check("rst_cdb_we",     int'(bus.cdb_we), 0);
    check("rst_cdb_addr",   int'(bus.cdb_addr), 0);
    check("rst_cdb_wdata",  int'(bus.cdb_wdata), 0);
    check("rst_clause_cnt", int'(bus.clause_cnt), 0);
    check("rst_sat_start",  int'(bus.sat_start), 0);
    check("rst_load_busy",  int'(bus.load_busy), 0);
    check("rst_load_err",   int'(bus.load_err), 0);
    rst = 1'b0;
    tick();

    // Table-driven single-clause sessions
    for (int i = 0; i < 6; i++) begin
      n_cl = 1;
      cl_len[0] = int'(tbl[i].len);
      for (int k = 0; k < ML; k++) begin
        cl_var[0][k] = int'(tbl[i].v[k]);
        cl_neg[0][k] = tbl[i].n[k];
      end
      drive_session(1'b0);
      exp_w = 1;
`ifdef CDB_TAUTOLOGY_DROP_EN
      if (tbl[i].taut) exp_w = 0;
      check($sformatf("vec%0d_taut_drop", i), taut_cnt, int'(tbl[i].taut));
`endif
      check($sformatf("vec%0d_nwrites", i), got_addr.size(), exp_w);
      if (exp_w == 1 && got_addr.size() == 1) begin
        check($sformatf("vec%0d_addr", i), got_addr[0], 0);
        check($sformatf("vec%0d_wdata", i), got_data[0], int'(tbl[i].word));
      end
      check($sformatf("vec%0d_clause_cnt", i), int'(bus.clause_cnt), exp_w);
      check($sformatf("vec%0d_sat", i), sat_cnt, 1);
      check($sformatf("vec%0d_err", i), int'(bus.load_err), 0);
      $display("vec%0d: writes=%0d cnt=%0d", i, got_addr.size(), bus.clause_cnt);
    end

    // Capacity: 7 one-literal clauses, no empty-clause marker
    n_cl = CN;
    for (int c = 0; c < CN; c++) begin
      cl_len[c] = 1; cl_var[c][0] = c + 1; cl_neg[c][0] = c[0];
    end
    drive_session(1'b0);
    check_session("capacity");
    $display("capacity: writes=%0d cnt=%0d", got_addr.size(), bus.clause_cnt);

    // load_start while in LOAD must not disturb the session
    clear_capture();
    start_load();
    send_lit(1, 1'b0, 1'b0);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    send_lit(2, 1'b0, 1'b0);
    send_lit(0, 1'b0, 1'b0);
    send_lit(0, 1'b0, 1'b0);
    wait_idle();
    check("ignore_start_nwrites", got_addr.size(), 1);
    if (got_addr.size() == 1) check("ignore_start_wdata", got_data[0], 5);
    check("ignore_start_cnt", int'(bus.clause_cnt), 1);
    $display("ignore_start: writes=%0d", got_addr.size());

    // Too many literals in one clause
    clear_capture();
    start_load();
    send_lit(1, 1'b0, 1'b0);
    send_lit(2, 1'b0, 1'b0);
    send_lit(3, 1'b1, 1'b0);
    check("maxlits_no_err_yet", int'(bus.load_err), 0);
    send_lit(4, 1'b0, 1'b0);
    check("maxlits_err", int'(bus.load_err), 1);
    check("maxlits_ready", int'(bus.lit_ready), 0);
    check("maxlits_busy", int'(bus.load_busy), 0);
    repeat (3) tick();
    check("maxlits_err_sticky", int'(bus.load_err), 1);
    check("maxlits_nwrites", got_addr.size(), 0);
    check("maxlits_sat", sat_cnt, 0);
    $display("maxlits: err=%0d writes=%0d", bus.load_err, got_addr.size());
    // Recovery from ERR via load_start
    n_cl = 1; cl_len[0] = 1; cl_var[0][0] = 5; cl_neg[0][0] = 1'b0;
    drive_session(1'b0);
    check_session("recover");
    $display("recover: writes=%0d err=%0d", got_addr.size(), bus.load_err);

    // Out-of-range variable on the VAR_NUM = 6 instance
    bus6.load_start = 1'b1;
    tick();
    bus6.load_start = 1'b0;
    check("oob_ready_before", int'(bus6.lit_ready), 1);
    bus6.lit_valid = 1'b1;
    bus6.lit_var   = 3'd7;
    tick();
    bus6.lit_valid = 1'b0;
    bus6.lit_var   = '0;
    check("oob_err", int'(bus6.load_err), 1);
    check("oob_ready", int'(bus6.lit_ready), 0);
    repeat (3) tick();
    check("oob_no_write", w_cnt6, 0);
    check("oob_no_sat", int'(bus6.sat_start), 0);
    $display("oob: err=%0d writes=%0d", bus6.load_err, w_cnt6);

    // Reset during the WRITE cycle of clause 2
    clear_capture();
    start_load();
    send_lit(1, 1'b0, 1'b0);
    send_lit(0, 1'b0, 1'b0);
    send_lit(2, 1'b0, 1'b0);
    send_lit(0, 1'b0, 1'b0);
    check("midrst_in_write", int'(bus.cdb_we), 1);
    check("midrst_write_addr", int'(bus.cdb_addr), 1);
    rst = 1'b1;
    tick();
    check("midrst_we", int'(bus.cdb_we), 0);
    check("midrst_ready", int'(bus.lit_ready), 0);
    check("midrst_busy", int'(bus.load_busy), 0);
    check("midrst_cnt", int'(bus.clause_cnt), 0);
    check("midrst_wdata", int'(bus.cdb_wdata), 0);
    check("midrst_sat", int'(bus.sat_start), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_nwrites", got_addr.size(), 1);
    check("midrst_idle_busy", int'(bus.load_busy), 0);
    n_cl = 1; cl_len[0] = 1; cl_var[0][0] = 3; cl_neg[0][0] = 1'b0;
    drive_session(1'b0);
    check_session("reload");
    $display("reload: writes=%0d addr0=%0d", got_addr.size(),
             (got_addr.size() > 0) ? got_addr[0] : -1);

    // Randomized sessions with random gaps, against the reference model
    for (int s = 0; s < 14; s++) begin
      n_cl = $urandom_range(1, CN);
      for (int c = 0; c < n_cl; c++) begin
        cl_len[c] = $urandom_range(1, ML);
        for (int k = 0; k < ML; k++) begin
          cl_var[c][k] = $urandom_range(1, VN);
          cl_neg[c][k] = 1'($urandom_range(0, 1));
        end
      end
      drive_session(1'b1);
      check_session($sformatf("rand%0d", s));
      $display("rand%0d: clauses=%0d writes=%0d cnt=%0d", s, n_cl, got_addr.size(),
               bus.clause_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
